lcd_bus_rx: RTL and testbench
=============================

LCD_BUS_RX -- requirements
Module: lcd_bus_rx

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 37, meaning the busy duration in clk cycles after any accepted write except clear.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 152, meaning the minimum busy duration in clk cycles after a clear command.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports lcd_e, lcd_rs, lcd_rw, input, 1 bit each: bus enable, register select (0 = instruction, 1 = data), read/write (1 = read).
REQ-006 SHALL have port db_in, input, 8 bits: bus data from the initiator.
REQ-007 SHALL have ports db_out (output, 8 bits) and db_oe (output, 1 bit): read data and its drive enable.
REQ-008 SHALL have ports busy, disp_on, cursor_on, blink_on, entry_inc, func_8bit, two_line, cmd_err, each an output of 1 bit: decoded controller status.
REQ-009 SHALL have ports addr (output, 7 bits: current DDRAM address) and dbg_rdata (output, 8 bits: DDRAM[dbg_raddr]), with dbg_raddr an input of 7 bits.

Function
REQ-010 SHALL pass lcd_e, lcd_rs, lcd_rw and db_in through a 2-flop synchronizer, and SHALL sample a bus transfer on the cycle a synchronized 1->0 edge of lcd_e is detected.
REQ-011 SHALL contain a 128x8 DDRAM, FSM states IDLE, EXEC and CLEAR, and a busy down-counter.
REQ-012 A write accepted in IDLE SHALL take effect on the cycle after the edge and SHALL move the FSM to EXEC, with busy=1 for exactly BUSY_CYCLES cycles; on expiry the FSM SHALL return to IDLE.
REQ-013 Instruction decode (first match from the MSB): 1aaaaaaa sets addr=a; 01xxxxxx (CGRAM address) is accepted with no other effect; 001DNFxx sets func_8bit=D and two_line=N; 0001SRxx with S=0 moves addr by +1 (R=1) or -1 (R=0), and with S=1 has no effect; 00001DCB sets disp_on, cursor_on and blink_on; 000001IS sets entry_inc=I, and S is ignored; 0000001x sets addr=0; 00000001 is clear; 00000000 is accepted with no effect.
REQ-014 A data write (rs=1, rw=0) SHALL store db_in to DDRAM[addr], then advance addr by +1 if entry_inc=1, otherwise by -1.
REQ-015 Address advance SHALL wrap 0x27->0x40, 0x67->0x00, 0x00->0x67 (decrement) and 0x40->0x27 (decrement); addr SHALL only hold 0x00-0x27 or 0x40-0x67, and a set-address value outside these ranges SHALL be clamped to 0x00.
REQ-016 Clear SHALL enter CLEAR, write 0x20 to all 128 DDRAM entries (one per cycle, index 0..127), set addr=0 and entry_inc=1, and hold busy=1 for max(128, CLEAR_CYCLES) cycles.
REQ-017 Any write transfer arriving while busy=1 SHALL be ignored and SHALL set cmd_err (sticky until reset).
REQ-018 On a synchronized rising edge of lcd_e with rw=1, db_oe SHALL go to 1 and hold until the falling edge; db_out SHALL be {busy, addr} for rs=0, or DDRAM[addr] for rs=1.
REQ-019 A data read SHALL advance addr per REQ-015 on its falling edge, only when busy=0; a status read SHALL have no side effect and SHALL be allowed while busy.
REQ-020 dbg_rdata SHALL be combinational from DDRAM.

Reset
REQ-021 rst_n=0 SHALL force: FSM=IDLE, busy=0, addr=0, disp_on=0, cursor_on=0, blink_on=0, entry_inc=1, func_8bit=1, two_line=0, cmd_err=0, db_out=0x00, db_oe=0, synchronizers=0.
REQ-022 Reset SHALL NOT clear DDRAM; a reset arriving during CLEAR SHALL abort the sweep, leaving the entries not yet written unchanged.

Configuration
REQ-023 With macro LCD_BUS_RX_READ_EN defined, reads SHALL behave per REQ-018 and REQ-019.
REQ-024 Without LCD_BUS_RX_READ_EN, db_oe SHALL be tied to 0, db_out SHALL be tied to 0x00, and read transfers SHALL have no effect.

Structure
REQ-025 The shared package SHALL hold the instruction opcode masks, the ASCII_BLANK (0x20) constant, the FSM state encoding, and the address wrap limits 0x27, 0x40 and 0x67.
REQ-026 The block SHALL contain one sub-module, lcd_addr_step, which is combinational and computes the next address for the +1/-1 step with wrap.

Verification
REQ-027 Scenario: reset, then write instruction 0x80 followed by data 0x41 -> DDRAM[0x00]=0x41, addr=0x01, busy high for 37 cycles after each write.
REQ-028 Scenario: set address 0xA7 (addr 0x27), write data 0x42 -> DDRAM[0x27]=0x42, addr=0x40; then write entry-mode 0x04, set address 0x80, write data -> addr=0x67.
REQ-029 Scenario: write clear 0x01 -> busy high for 152 cycles, all entries 0x20, addr=0; a data write issued at cycle 10 of the clear -> ignored and cmd_err=1.
REQ-030 Scenario: write 0x0F, then 0x38 -> disp_on=1, cursor_on=1, blink_on=1, func_8bit=1, two_line=1.
REQ-031 Scenario (READ_EN): status read during busy after a write to addr 5 -> db_out=0x86; data read at addr 0x40 holding 0x33 -> db_out=0x33, addr=0x41 after the E falling edge.
REQ-032 Scenario: assert rst_n=0 at sweep index 60 of a clear -> busy=0, addr=0; entries 0-59 read 0x20 and entries 60-127 keep their prior contents.

Source files
------------

// File: rtl/lcd_bus_rx_pkg.sv
// lcd_bus_rx_pkg -- shared definitions for the LCD bus receiver.
//   * FSM state encoding
//   * instruction opcode mask/match pairs (matched MSB first)
//   * ASCII_BLANK fill value and the DDRAM address window limits
//   * op_match / addr_clamp helper functions
package lcd_bus_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_CLEAR = 2'd2
  } lcd_state_e;

  localparam logic [7:0] ASCII_BLANK = 8'h20;

  // Two visible line windows: 0x00..0x27 and 0x40..0x67.
  localparam logic [6:0] ADDR_L1_BEG = 7'h00;
  localparam logic [6:0] ADDR_L1_END = 7'h27;
  localparam logic [6:0] ADDR_L2_BEG = 7'h40;
  localparam logic [6:0] ADDR_L2_END = 7'h67;

  localparam logic [7:0] OP_DDRAM_MSK = 8'h80, OP_DDRAM_VAL = 8'h80;
  localparam logic [7:0] OP_CGRAM_MSK = 8'hC0, OP_CGRAM_VAL = 8'h40;
  localparam logic [7:0] OP_FUNC_MSK  = 8'hE0, OP_FUNC_VAL  = 8'h20;
  localparam logic [7:0] OP_SHIFT_MSK = 8'hF0, OP_SHIFT_VAL = 8'h10;
  localparam logic [7:0] OP_DISP_MSK  = 8'hF8, OP_DISP_VAL  = 8'h08;
  localparam logic [7:0] OP_ENTRY_MSK = 8'hFC, OP_ENTRY_VAL = 8'h04;
  localparam logic [7:0] OP_HOME_MSK  = 8'hFE, OP_HOME_VAL  = 8'h02;
  localparam logic [7:0] OP_CLEAR_MSK = 8'hFF, OP_CLEAR_VAL = 8'h01;

  function automatic logic op_match(input logic [7:0] d,
                                    input logic [7:0] msk,
                                    input logic [7:0] val);
    return (d & msk) == val;
  endfunction

  // Addresses outside both line windows collapse to the home position.
  function automatic logic [6:0] addr_clamp(input logic [6:0] a);
    if ((a <= ADDR_L1_END) || ((a >= ADDR_L2_BEG) && (a <= ADDR_L2_END)))
      return a;
    return ADDR_L1_BEG;
  endfunction

endpackage

// File: rtl/lcd_bus_rx_if.sv
// lcd_bus_rx_if -- parallel LCD bus between an initiator (master) and the
// receiver (slave).
//   lcd_e   : enable strobe, transfer sampled on its falling edge
//   lcd_rs  : 0 = instruction/status, 1 = data
//   lcd_rw  : 1 = read
//   db_in   : write data from the initiator
//   db_out  : read data from the receiver, valid while db_oe = 1
interface lcd_bus_rx_if;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] db_in;
  logic [7:0] db_out;
  logic       db_oe;

  modport master (output lcd_e, lcd_rs, lcd_rw, db_in, input db_out, db_oe);
  modport slave  (input lcd_e, lcd_rs, lcd_rw, db_in, output db_out, db_oe);
endinterface

// File: rtl/lcd_bus_rx_addr_step.sv
// lcd_addr_step -- combinational next-address for a +1/-1 cursor step.
// Stepping wraps between the two line windows:
//   +1 : 0x27 -> 0x40, 0x67 -> 0x00
//   -1 : 0x00 -> 0x67, 0x40 -> 0x27
// Ports: i_addr (current address), i_inc (1 = +1, 0 = -1), o_addr (result).
module lcd_addr_step
  import lcd_bus_rx_pkg::*;
(
  input  logic [6:0] i_addr,
  input  logic       i_inc,
  output logic [6:0] o_addr
);

  always_comb begin
    o_addr = i_addr;
    if (i_inc) begin
      if (i_addr == ADDR_L1_END)      o_addr = ADDR_L2_BEG;
      else if (i_addr == ADDR_L2_END) o_addr = ADDR_L1_BEG;
      else                            o_addr = i_addr + 7'd1;
    end else begin
      if (i_addr == ADDR_L1_BEG)      o_addr = ADDR_L2_END;
      else if (i_addr == ADDR_L2_BEG) o_addr = ADDR_L1_END;
      else                            o_addr = i_addr - 7'd1;
    end
  end

endmodule

// File: rtl/lcd_bus_rx.sv
// lcd_bus_rx -- receiver side of an HD44780-style LCD parallel bus.
// Synchronises the asynchronous bus, decodes instruction/data writes into a
// 128x8 DDRAM plus controller status, and models the controller busy time.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : lcd_e/lcd_rs/lcd_rw/db_in in, db_out/db_oe out
//   busy               : write in progress, further writes are rejected
//   disp_on, cursor_on, blink_on, entry_inc, func_8bit, two_line : status
//   cmd_err            : sticky, a write arrived while busy
//   addr               : current DDRAM address
//   dbg_raddr/dbg_rdata: combinational DDRAM peek port
//
// Build option: define LCD_BUS_RX_READ_EN to enable bus reads (status and
// data). Without it db_oe/db_out are tied low and read transfers are ignored.
module lcd_bus_rx
  import lcd_bus_rx_pkg::*;
#(
  parameter int BUSY_CYCLES  = 37,
  parameter int CLEAR_CYCLES = 152
) (
  input  logic         clk,
  input  logic         rst_n,
  lcd_bus_rx_if.slave  bus,
  output logic         busy,
  output logic         disp_on,
  output logic         cursor_on,
  output logic         blink_on,
  output logic         entry_inc,
  output logic         func_8bit,
  output logic         two_line,
  output logic         cmd_err,
  output logic [6:0]   addr,
  input  logic [6:0]   dbg_raddr,
  output logic [7:0]   dbg_rdata
);

  // The clear sweep needs 128 cycles even if CLEAR_CYCLES is shorter.
  localparam int CLR_TOTAL = (CLEAR_CYCLES > 128) ? CLEAR_CYCLES : 128;
  localparam int CNT_MAX   = (CLR_TOTAL > BUSY_CYCLES) ? CLR_TOTAL : BUSY_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLR_TOTAL - 1);

  lcd_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_clr_idx;
  logic             r_busy;
  logic [6:0]       r_addr;
  logic             r_disp_on, r_cursor_on, r_blink_on;
  logic             r_entry_inc, r_func_8bit, r_two_line, r_cmd_err;

  logic       r_e_p0, r_e_p1, r_e_p2;
  logic       r_rs_p0, r_rs_p1;
  logic       r_rw_p0, r_rw_p1;
  logic [7:0] r_db_p0, r_db_p1;

  logic [7:0] r_mem [0:127];

  logic       w_fall, w_wr, w_instr, w_dwr, w_rd_adv;
  logic       w_step_inc;
  logic [6:0] w_addr_next;
  logic       w_mem_we;
  logic [6:0] w_mem_wa;
  logic [7:0] w_mem_wd;

  // Stage boundary: bus inputs -> 2-flop synchronisers (_p0, _p1); _p2 keeps
  // the previous enable level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_p0  <= 1'b0;
      r_e_p1  <= 1'b0;
      r_e_p2  <= 1'b0;
      r_rs_p0 <= 1'b0;
      r_rs_p1 <= 1'b0;
      r_rw_p0 <= 1'b0;
      r_rw_p1 <= 1'b0;
      r_db_p0 <= 8'h00;
      r_db_p1 <= 8'h00;
    end else begin
      r_e_p0  <= bus.lcd_e;
      r_e_p1  <= r_e_p0;
      r_e_p2  <= r_e_p1;
      r_rs_p0 <= bus.lcd_rs;
      r_rs_p1 <= r_rs_p0;
      r_rw_p0 <= bus.lcd_rw;
      r_rw_p1 <= r_rw_p0;
      r_db_p0 <= bus.db_in;
      r_db_p1 <= r_db_p0;
    end
  end

  assign w_fall  = r_e_p2 & ~r_e_p1;
  assign w_wr    = w_fall & ~r_rw_p1;
  assign w_instr = w_wr & (r_state == ST_IDLE) & ~r_rs_p1;
  assign w_dwr   = w_wr & (r_state == ST_IDLE) &  r_rs_p1;

  // Cursor-shift instructions choose their own direction; data accesses
  // follow the entry mode.
  assign w_step_inc = w_instr ? r_db_p1[2] : r_entry_inc;

  lcd_addr_step u_addr_step (
    .i_addr (r_addr),
    .i_inc  (w_step_inc),
    .o_addr (w_addr_next)
  );

`ifdef LCD_BUS_RX_READ_EN
  logic       w_rise;
  logic       r_db_oe;
  logic [7:0] r_db_out;

  assign w_rise   = r_e_p1 & ~r_e_p2;
  assign w_rd_adv = w_fall & r_rw_p1 & r_rs_p1 & (r_state == ST_IDLE);

  // Stage boundary: read data is captured on the enable rising edge and
  // driven until the falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_oe  <= 1'b0;
      r_db_out <= 8'h00;
    end else if (w_rise && r_rw_p1) begin
      r_db_oe  <= 1'b1;
      r_db_out <= r_rs_p1 ? r_mem[r_addr] : {r_busy, r_addr};
    end else if (w_fall) begin
      r_db_oe  <= 1'b0;
    end
  end

  assign bus.db_oe  = r_db_oe;
  assign bus.db_out = r_db_out;
`else
  assign w_rd_adv   = 1'b0;
  assign bus.db_oe  = 1'b0;
  assign bus.db_out = 8'h00;
`endif

  // Stage boundary: controller FSM, status registers and busy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_clr_idx   <= 8'h00;
      r_busy      <= 1'b0;
      r_addr      <= 7'h00;
      r_disp_on   <= 1'b0;
      r_cursor_on <= 1'b0;
      r_blink_on  <= 1'b0;
      r_entry_inc <= 1'b1;
      r_func_8bit <= 1'b1;
      r_two_line  <= 1'b0;
      r_cmd_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_instr) begin
            r_state <= ST_EXEC;
            r_busy  <= 1'b1;
            r_cnt   <= BUSY_LOAD;
            if (op_match(r_db_p1, OP_DDRAM_MSK, OP_DDRAM_VAL)) begin
              r_addr <= addr_clamp(r_db_p1[6:0]);
            end else if (op_match(r_db_p1, OP_CGRAM_MSK, OP_CGRAM_VAL)) begin
              r_addr <= r_addr;
            end else if (op_match(r_db_p1, OP_FUNC_MSK, OP_FUNC_VAL)) begin
              r_func_8bit <= r_db_p1[4];
              r_two_line  <= r_db_p1[3];
            end else if (op_match(r_db_p1, OP_SHIFT_MSK, OP_SHIFT_VAL)) begin
              // S=1 (display shift) has no effect on the stored address.
              if (!r_db_p1[3]) r_addr <= w_addr_next;
            end else if (op_match(r_db_p1, OP_DISP_MSK, OP_DISP_VAL)) begin
              r_disp_on   <= r_db_p1[2];
              r_cursor_on <= r_db_p1[1];
              r_blink_on  <= r_db_p1[0];
            end else if (op_match(r_db_p1, OP_ENTRY_MSK, OP_ENTRY_VAL)) begin
              r_entry_inc <= r_db_p1[1];
            end else if (op_match(r_db_p1, OP_HOME_MSK, OP_HOME_VAL)) begin
              r_addr <= ADDR_L1_BEG;
            end else if (op_match(r_db_p1, OP_CLEAR_MSK, OP_CLEAR_VAL)) begin
              r_state     <= ST_CLEAR;
              r_cnt       <= CLEAR_LOAD;
              r_clr_idx   <= 8'h00;
              r_addr      <= ADDR_L1_BEG;
              r_entry_inc <= 1'b1;
            end
          end else if (w_dwr) begin
            r_state <= ST_EXEC;
            r_busy  <= 1'b1;
            r_cnt   <= BUSY_LOAD;
            r_addr  <= w_addr_next;
          end else if (w_rd_adv) begin
            r_addr <= w_addr_next;
          end
        end
        ST_EXEC, ST_CLEAR: begin
          if (w_wr) r_cmd_err <= 1'b1;
          // Bit 7 of the sweep index marks all 128 entries done.
          if ((r_state == ST_CLEAR) && !r_clr_idx[7]) r_clr_idx <= r_clr_idx + 8'd1;
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // DDRAM has no reset: an aborted clear leaves unswept entries intact
  // because the FSM drops out of ST_CLEAR asynchronously.
  assign w_mem_we = ((r_state == ST_CLEAR) && !r_clr_idx[7]) || w_dwr;
  assign w_mem_wa = (r_state == ST_CLEAR) ? r_clr_idx[6:0] : r_addr;
  assign w_mem_wd = (r_state == ST_CLEAR) ? ASCII_BLANK : r_db_p1;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_wa] <= w_mem_wd;
  end

  assign dbg_rdata = r_mem[dbg_raddr];

  assign busy      = r_busy;
  assign addr      = r_addr;
  assign disp_on   = r_disp_on;
  assign cursor_on = r_cursor_on;
  assign blink_on  = r_blink_on;
  assign entry_inc = r_entry_inc;
  assign func_8bit = r_func_8bit;
  assign two_line  = r_two_line;
  assign cmd_err   = r_cmd_err;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// tb_lcd_bus_rx -- directed, table-driven bench for lcd_bus_rx.
// Works in both builds; read expectations depend on LCD_BUS_RX_READ_EN.
module tb_lcd_bus_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy, disp_on, cursor_on, blink_on, entry_inc, func_8bit, two_line, cmd_err;
  logic [6:0] addr;
  logic [6:0] dbg_raddr = 7'h00;
  logic [7:0] dbg_rdata;

  lcd_bus_rx_if bif ();

  lcd_bus_rx #(.BUSY_CYCLES(37), .CLEAR_CYCLES(152)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bif),
    .busy      (busy),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .entry_inc (entry_inc),
    .func_8bit (func_8bit),
    .two_line  (two_line),
    .cmd_err   (cmd_err),
    .addr      (addr),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [6:0] ea;     // expected addr after the write
    logic [5:0] ef;     // {disp,cursor,blink,entry_inc,func_8bit,two_line}
    logic       mc;     // check a DDRAM location
    logic [6:0] ma;
    logic [7:0] md;
  } vec_t;

  vec_t tbl [28];

  logic [7:0] cap_out;
  logic       cap_oe;
  int         bw;

  function automatic logic [5:0] flags();
    return {disp_on, cursor_on, blink_on, entry_inc, func_8bit, two_line};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One bus transfer; db_out/db_oe are captured just before E falls.
  task automatic xfer(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bif.lcd_rs = rs;
    bif.lcd_rw = rw;
    bif.db_in  = d;
    repeat (3) @(negedge clk);
    bif.lcd_e = 1'b1;
    repeat (5) @(negedge clk);
    cap_out = bif.db_out;
    cap_oe  = bif.db_oe;
    bif.lcd_e = 1'b0;
  endtask

  // Busy cycles seen after a transfer; 0 if busy never rises.
  task automatic measure_busy(output int w);
    w = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (busy) w++;
      else if (w > 0) break;
    end
  endtask

  task automatic wait_idle();
    repeat (4) @(negedge clk);
    for (int n = 0; n < 400 && busy; n++) @(negedge clk);
    check("wait_idle_timeout", busy, 1'b0);
  endtask

  task automatic wait_busy();
    for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
    check("busy_rise", busy, 1'b1);
  endtask

  task automatic peek(input logic [6:0] a, output logic [7:0] d);
    dbg_raddr = a;
    #1;
    d = dbg_rdata;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_addr"}, addr, 7'h00);
    check({tag, "_flags"}, flags(), 6'b000110);
    check({tag, "_cmd_err"}, cmd_err, 1'b0);
    check({tag, "_db_oe"}, bif.db_oe, 1'b0);
    check({tag, "_db_out"}, bif.db_out, 8'h00);
  endtask

  initial begin
    logic [7:0] rd;
    int         nb;
    bif.lcd_e = 1'b0; bif.lcd_rs = 1'b0; bif.lcd_rw = 1'b0; bif.db_in = 8'h00;

    //             rs    d      ea     ef          mc    ma     md
    tbl[0]  = '{1'b0, 8'h80, 7'h00, 6'b000110, 1'b0, 7'h00, 8'h00};
    tbl[1]  = '{1'b1, 8'h41, 7'h01, 6'b000110, 1'b1, 7'h00, 8'h41};
    tbl[2]  = '{1'b0, 8'hA7, 7'h27, 6'b000110, 1'b0, 7'h00, 8'h00};
    tbl[3]  = '{1'b1, 8'h42, 7'h40, 6'b000110, 1'b1, 7'h27, 8'h42};
    tbl[4]  = '{1'b0, 8'h04, 7'h40, 6'b000010, 1'b0, 7'h00, 8'h00};
    tbl[5]  = '{1'b0, 8'h80, 7'h00, 6'b000010, 1'b0, 7'h00, 8'h00};
    tbl[6]  = '{1'b1, 8'h43, 7'h67, 6'b000010, 1'b1, 7'h00, 8'h43};
    tbl[7]  = '{1'b1, 8'h44, 7'h66, 6'b000010, 1'b1, 7'h67, 8'h44};
    tbl[8]  = '{1'b0, 8'hE8, 7'h00, 6'b000010, 1'b0, 7'h00, 8'h00};
    tbl[9]  = '{1'b0, 8'h55, 7'h00, 6'b000010, 1'b0, 7'h00, 8'h00};
    tbl[10] = '{1'b0, 8'h14, 7'h01, 6'b000010, 1'b0, 7'h00, 8'h00};
    tbl[11] = '{1'b0, 8'h10, 7'h00, 6'b000010, 1'b0, 7'h00, 8'h00};
    tbl[12] = '{1'b0, 8'h10, 7'h67, 6'b000010, 1'b0, 7'h00, 8'h00};
    tbl[13] = '{1'b0, 8'h1C, 7'h67, 6'b000010, 1'b0, 7'h00, 8'h00};
    tbl[14] = '{1'b0, 8'hC0, 7'h40, 6'b000010, 1'b0, 7'h00, 8'h00};
    tbl[15] = '{1'b0, 8'h10, 7'h27, 6'b000010, 1'b0, 7'h00, 8'h00};
    tbl[16] = '{1'b0, 8'h14, 7'h40, 6'b000010, 1'b0, 7'h00, 8'h00};
    tbl[17] = '{1'b0, 8'h06, 7'h40, 6'b000110, 1'b0, 7'h00, 8'h00};
    tbl[18] = '{1'b0, 8'h0F, 7'h40, 6'b111110, 1'b0, 7'h00, 8'h00};
    tbl[19] = '{1'b0, 8'h38, 7'h40, 6'b111111, 1'b0, 7'h00, 8'h00};
    tbl[20] = '{1'b0, 8'h23, 7'h40, 6'b111100, 1'b0, 7'h00, 8'h00};
    tbl[21] = '{1'b0, 8'h38, 7'h40, 6'b111111, 1'b0, 7'h00, 8'h00};
    tbl[22] = '{1'b0, 8'h0C, 7'h40, 6'b100111, 1'b0, 7'h00, 8'h00};
    tbl[23] = '{1'b0, 8'h85, 7'h05, 6'b100111, 1'b0, 7'h00, 8'h00};
    tbl[24] = '{1'b0, 8'h03, 7'h00, 6'b100111, 1'b0, 7'h00, 8'h00};
    tbl[25] = '{1'b0, 8'h00, 7'h00, 6'b100111, 1'b0, 7'h00, 8'h00};
    tbl[26] = '{1'b0, 8'hE7, 7'h67, 6'b100111, 1'b0, 7'h00, 8'h00};
    tbl[27] = '{1'b1, 8'h45, 7'h00, 6'b100111, 1'b1, 7'h67, 8'h45};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("rst1");

    // Table: write, measure busy, check decoded state
    for (int i = 0; i < 28; i++) begin
      xfer(tbl[i].rs, 1'b0, tbl[i].d);
      measure_busy(bw);
      check($sformatf("v%0d_busy_len", i), bw, 37);
      check($sformatf("v%0d_addr", i), addr, tbl[i].ea);
      check($sformatf("v%0d_flags", i), flags(), tbl[i].ef);
      if (tbl[i].mc) begin
        peek(tbl[i].ma, rd);
        check($sformatf("v%0d_mem", i), rd, tbl[i].md);
      end
    end
    check("tbl_cmd_err", cmd_err, 1'b0);

    // Status read while busy, then data read with address advance
    xfer(1'b0, 1'b0, 8'h85);
    wait_idle();
    xfer(1'b1, 1'b0, 8'h77);
    xfer(1'b0, 1'b1, 8'h00);
`ifdef LCD_BUS_RX_READ_EN
    check("status_rd_oe", cap_oe, 1'b1);
    check("status_rd_out", cap_out, 8'h86);
`else
    check("status_rd_oe", cap_oe, 1'b0);
    check("status_rd_out", cap_out, 8'h00);
`endif
    wait_idle();
    check("status_rd_no_err", cmd_err, 1'b0);
    check("status_rd_addr", addr, 7'h06);
    xfer(1'b0, 1'b0, 8'hC0);
    wait_idle();
    xfer(1'b1, 1'b0, 8'h33);
    wait_idle();
    xfer(1'b0, 1'b0, 8'hC0);
    wait_idle();
    xfer(1'b1, 1'b1, 8'h00);
    repeat (5) @(negedge clk);
    check("data_rd_busy", busy, 1'b0);
    check("data_rd_oe_after", bif.db_oe, 1'b0);
`ifdef LCD_BUS_RX_READ_EN
    check("data_rd_oe", cap_oe, 1'b1);
    check("data_rd_out", cap_out, 8'h33);
    check("data_rd_addr", addr, 7'h41);
`else
    check("data_rd_oe", cap_oe, 1'b0);
    check("data_rd_out", cap_out, 8'h00);
    check("data_rd_addr", addr, 7'h40);
`endif

    // Clear: busy length, blank fill, addr/entry mode
    xfer(1'b0, 1'b0, 8'h04);
    wait_idle();
    check("pre_clr_inc", entry_inc, 1'b0);
    xfer(1'b0, 1'b0, 8'h01);
    measure_busy(bw);
    check("clr_busy_len", bw, 152);
    check("clr_addr", addr, 7'h00);
    check("clr_entry_inc", entry_inc, 1'b1);
    nb = 0;
    for (int a = 0; a < 128; a++) begin
      peek(7'(a), rd);
      if (rd !== 8'h20) nb++;
    end
    check("clr_nonblank_count", nb, 0);

    // Write during clear is rejected and flags cmd_err
    xfer(1'b0, 1'b0, 8'h01);
    wait_busy();
    repeat (10) @(negedge clk);
    xfer(1'b1, 1'b0, 8'h99);
    wait_idle();
    check("busy_wr_err", cmd_err, 1'b1);
    check("busy_wr_addr", addr, 7'h00);
    peek(7'h00, rd);
    check("busy_wr_mem", rd, 8'h20);

    // Reset clears status, including sticky cmd_err
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("rst2");

    // Reset in the middle of a clear sweep
    xfer(1'b0, 1'b0, 8'hC0); wait_idle();
    xfer(1'b1, 1'b0, 8'h55); wait_idle();
    xfer(1'b1, 1'b0, 8'h66); wait_idle();
    xfer(1'b0, 1'b0, 8'h85); wait_idle();
    xfer(1'b1, 1'b0, 8'h77); wait_idle();
    xfer(1'b0, 1'b0, 8'hA7); wait_idle();
    xfer(1'b1, 1'b0, 8'h39); wait_idle();
    peek(7'h40, rd);
    check("pre_abort_m40", rd, 8'h55);
    xfer(1'b0, 1'b0, 8'h01);
    wait_busy();
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_addr", addr, 7'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_stays_idle", busy, 1'b0);
    peek(7'h05, rd);  check("abort_m05", rd, 8'h20);
    peek(7'h27, rd);  check("abort_m27", rd, 8'h20);
    peek(7'd59, rd);  check("abort_m59", rd, 8'h20);
    peek(7'h40, rd);  check("abort_m40", rd, 8'h55);
    peek(7'h41, rd);  check("abort_m41", rd, 8'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
